// File: rtl/led_pwm_fader.sv
// Per-channel PWM fader for the board LED pins.
// Levels glide toward a brightness-capped target once per PWM frame.
module led_pwm_fader #(
  parameter int   CLK_IN_MHZ   = 12,
  parameter int   PWM_HZ       = 1000,
  parameter int   FADE_STEP    = 8,
  parameter logic IN_POLARITY  = 1'b1,
  parameter logic LED_POLARITY = 1'b1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] led_i,
  input  logic [3:0] bright_i,
  output logic [7:0] led_o,
  output logic       frame_o
);

  localparam int RAW_DIV  = (CLK_IN_MHZ * 1_000_000) / (PWM_HZ * 255);
  localparam int TICK_DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [8:0]    STEP    = 9'(FADE_STEP);

  logic [PW-1:0] pre_q;
  logic [7:0]    pwm_q;
  logic [7:0]    level_q [8];
  logic [7:0]    level_d [8];
  logic          tick;
  logic [7:0]    ceiling;

  assign tick    = (pre_q == PRE_MAX);
  assign frame_o = tick && (pwm_q == 8'd254);
  assign ceiling = {4'b0000, bright_i} * 8'd17;

  // 9-bit math so neither the add nor the subtract can wrap.
  function automatic logic [7:0] fade(
    input logic [7:0] lvl,
    input logic [7:0] tgt
  );
    logic [8:0] l9;
    logic [8:0] t9;
    logic [8:0] up;
    logic [8:0] dn;
    l9 = {1'b0, lvl};
    t9 = {1'b0, tgt};
    up = l9 + STEP;
    dn = (l9 > STEP) ? (l9 - STEP) : 9'd0;
    unique case (1'b1)
      (l9 < t9): fade = (up > t9) ? tgt : up[7:0];
      (l9 > t9): fade = (dn < t9) ? tgt : dn[7:0];
      default:   fade = lvl;
    endcase
  endfunction

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      level_d[n] = fade(level_q[n],
        (led_i[n] == IN_POLARITY) ? ceiling : 8'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pre_q <= '0;
      pwm_q <= '0;
      led_o <= {8{~LED_POLARITY}};
      for (int n = 0; n < 8; n++) begin
        level_q[n] <= '0;
      end
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        pwm_q <= (pwm_q == 8'd254) ? 8'd0 : pwm_q + 8'd1;
      end
      if (frame_o) begin
        for (int n = 0; n < 8; n++) begin
          level_q[n] <= level_d[n];
        end
      end
      for (int n = 0; n < 8; n++) begin
        led_o[n] <= (pwm_q < level_q[n]) ? LED_POLARITY : ~LED_POLARITY;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: two instances, opposite polarities,
// on-time per frame compared against a frame-level fade model.
module tb_led_pwm_fader;

  localparam int A_MHZ = 1;
  localparam int A_HZ  = 1500;
  localparam int B_MHZ = 1;
  localparam int B_HZ  = 4000;
  localparam int A_RAW = (A_MHZ * 1000000) / (A_HZ * 255);
  localparam int B_RAW = (B_MHZ * 1000000) / (B_HZ * 255);
  localparam int TD_A  = (A_RAW < 1) ? 1 : A_RAW;
  localparam int TD_B  = (B_RAW < 1) ? 1 : B_RAW;
  localparam int N_A   = 81;

  logic       clk;
  logic       rstn;
  logic [7:0] led_in  [2];
  logic [3:0] bright  [2];
  logic [7:0] led_out [2];
  logic       fr_o    [2];

  int td [2] = '{TD_A, TD_B};
  int fl [2] = '{TD_A * 255, TD_B * 255};
  int fs [2] = '{8, 255};
  int ip [2] = '{1, 0};
  int lp [2] = '{1, 0};

  int lvl [2][8];
  logic [63:0] q_a [$];
  logic [63:0] q_b [$];

  int checks = 0;
  int errors = 0;

  led_pwm_fader #(
    .CLK_IN_MHZ(A_MHZ), .PWM_HZ(A_HZ), .FADE_STEP(8),
    .IN_POLARITY(1'b1), .LED_POLARITY(1'b1)
  ) u_a (
    .clk_i(clk), .rstn_i(rstn), .led_i(led_in[0]),
    .bright_i(bright[0]), .led_o(led_out[0]), .frame_o(fr_o[0])
  );

  led_pwm_fader #(
    .CLK_IN_MHZ(B_MHZ), .PWM_HZ(B_HZ), .FADE_STEP(255),
    .IN_POLARITY(1'b0), .LED_POLARITY(1'b0)
  ) u_b (
    .clk_i(clk), .rstn_i(rstn), .led_i(led_in[1]),
    .bright_i(bright[1]), .led_o(led_out[1]), .frame_o(fr_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 8; n++) lvl[i][n] = 0;
    q_a.delete();
    q_b.delete();
  endtask

  // One frame of fading: move toward target by at most the step.
  task automatic model_step(input int idx, input logic [7:0] l,
                            input logic [3:0] b);
    logic [63:0] e;
    int tgt;
    for (int n = 0; n < 8; n++) begin
      tgt = (int'(l[n]) == ip[idx]) ? int'(b) * 17 : 0;
      if (lvl[idx][n] < tgt)
        lvl[idx][n] = (lvl[idx][n] + fs[idx] > tgt) ? tgt : lvl[idx][n] + fs[idx];
      else if (lvl[idx][n] > tgt)
        lvl[idx][n] = (lvl[idx][n] - fs[idx] < tgt) ? tgt : lvl[idx][n] - fs[idx];
      e[n*8 +: 8] = 8'(lvl[idx][n]);
    end
    if (idx == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic pick(input int idx, input int f, input int phase,
                      output logic [7:0] l, output logic [3:0] b);
    logic [7:0] r;
    r = 8'($urandom);
    b = 4'd15;
    if (idx == 0) begin
      if (phase == 1)  l = 8'hFF;
      else if (f < 33) l = {r[7:1], 1'b1};
      else if (f < 66) l = {r[7:1], 1'b0};
      else             l = {r[7:1], 1'b1};
    end else begin
      if (phase == 1)  l = 8'h00;
      else if (f < 4)  l = 8'hFE;
      else if (f < 8)  begin l = 8'h00; b = 4'd4; end
      else if (f < 12) begin l = 8'h00; b = 4'd2; end
      else begin l = r; b = 4'($urandom); end
    end
  endtask

  task automatic stim(input int idx, input int nfr, input int phase);
    int ph;
    logic [7:0] l;
    logic [3:0] b;
    for (int k = 0; k < nfr * fl[idx]; k++) begin
      ph = k % fl[idx];
      if (ph >= fl[idx] - 2 || ph == 0)
        chk($sformatf("frame_o%0d_k%0d", idx, k), 32'(fr_o[idx]),
            32'(ph == fl[idx] - 1));
      if (ph == fl[idx] - 1) begin
        pick(idx, k / fl[idx], phase, l, b);
        led_in[idx] = l;
        bright[idx] = b;
        model_step(idx, l, b);
      end else if ($urandom_range(0, 63) == 0) begin
        led_in[idx] = 8'($urandom);
        bright[idx] = 4'($urandom);
      end
      @(negedge clk);
    end
  endtask

  // Counts active-level clocks per channel over each frame window
  // (output is registered, so the window lags frame_o by two clocks).
  task automatic monitor(input int idx);
    bit f1, f2, open, got;
    int cnt [8];
    logic [63:0] e;
    f1 = 0; f2 = 0; open = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        f1 = 0; f2 = 0; open = 0;
        continue;
      end
      if (f2) begin
        if (open)
          for (int n = 0; n < 8; n++)
            chk($sformatf("ontime%0d_ch%0d", idx, n), 32'(cnt[n]),
                32'(int'(e[n*8 +: 8]) * td[idx]));
        got = 0;
        if (idx == 0 && q_a.size() > 0) begin e = q_a.pop_front(); got = 1; end
        if (idx == 1 && q_b.size() > 0) begin e = q_b.pop_front(); got = 1; end
        open = got;
        for (int n = 0; n < 8; n++) cnt[n] = 0;
      end
      for (int n = 0; n < 8; n++)
        if (int'(led_out[idx][n]) == lp[idx]) cnt[n]++;
      f2 = f1;
      f1 = fr_o[idx];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      led_in[i] = 8'h00;
      bright[i] = 4'd0;
    end
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_led_a", 32'(led_out[0]), 32'h00);
    chk("rst_led_b", 32'(led_out[1]), 32'hFF);
    chk("rst_frame_a", 32'(fr_o[0]), 0);
    chk("rst_frame_b", 32'(fr_o[1]), 0);
    rstn = 1'b1;
    fork
      stim(0, N_A, 0);
      stim(1, N_A * fl[0] / fl[1], 0);
    join
    repeat (300) @(negedge clk);
    chk("pre_rst_level_a0", 32'(lvl[0][0]), 120);
    led_in[0] = 8'hFF;
    bright[0] = 4'd15;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_led_a", 32'(led_out[0]), 32'h00);
    chk("midrst_led_b", 32'(led_out[1]), 32'hFF);
    chk("midrst_frame_a", 32'(fr_o[0]), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    fork
      stim(0, 4, 1);
      stim(1, 4 * fl[0] / fl[1], 1);
    join
    repeat (fl[0] + 5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
